// File: rtl/mpq_cmd_arbiter.sv
// mpq_cmd_arbiter: round-robin arbiter that issues one command at a time to an MPQ.
// A watchdog bounds each command and traps the arbiter in an error state.
module mpq_cmd_arbiter #(
    parameter int NREQ   = 4,
    parameter int WD_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_cmd,
    input  logic [8*NREQ-1:0] req_index,
    input  logic [8*NREQ-1:0] req_value,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              mpq_cmd_valid,
    output logic [2:0]        mpq_cmd,
    output logic [7:0]        mpq_index,
    output logic [7:0]        mpq_value,
    input  logic              mpq_busy,
    input  logic              mpq_done,
    output logic              wd_err
);
    localparam int PW = $clog2(NREQ);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, ERR} state_t;
    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n, owner, owner_n, idx, win;
    logic [9:0]      wd, wd_n;
    logic            fresh, fresh_n, acked, acked_n, found, valid_n, err_n;
    logic [NREQ-1:0] mreq, gnt_n, ack_n;
    logic [2:0]      cmd_n;
    logic [7:0]      index_n, value_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= PW'(NREQ - 1);
            owner         <= '0;
            wd            <= '0;
            fresh         <= 1'b0;
            acked         <= 1'b0;
            gnt           <= '0;
            ack           <= '0;
            mpq_cmd_valid <= 1'b0;
            mpq_cmd       <= '0;
            mpq_index     <= '0;
            mpq_value     <= '0;
            wd_err        <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            owner         <= owner_n;
            wd            <= wd_n;
            fresh         <= fresh_n;
            acked         <= acked_n;
            gnt           <= gnt_n;
            ack           <= ack_n;
            mpq_cmd_valid <= valid_n;
            mpq_cmd       <= cmd_n;
            mpq_index     <= index_n;
            mpq_value     <= value_n;
            wd_err        <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        wd_n    = wd;
        fresh_n = fresh;
        acked_n = acked;
        gnt_n   = '0;
        ack_n   = '0;
        valid_n = 1'b0;
        cmd_n   = mpq_cmd;
        index_n = mpq_index;
        value_n = mpq_value;
        err_n   = wd_err;
        // The requester acked this cycle may still show req; keep it out of the search.
        mreq  = req & ~ack;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = ptr + PW'(k);
            if (!found && mreq[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        case (state)
            IDLE: begin
                if (!mpq_busy && found) begin
                    state_n = ISSUE;
                    ptr_n   = win;
                    owner_n = win;
                    gnt_n   = NREQ'(1) << win;
                    valid_n = 1'b1;
                    cmd_n   = req_cmd[3*int'(win) +: 3];
                    index_n = req_index[8*int'(win) +: 8];
                    value_n = req_value[8*int'(win) +: 8];
                end
            end
            ISSUE: begin
                wd_n    = '0;
                fresh_n = 1'b1;
                acked_n = 1'b0;
                state_n = mpq_cmd[2] ? DRAIN : WAIT;
            end
            WAIT, DRAIN: begin
                wd_n    = wd + 10'd1;
                fresh_n = 1'b0;
                if (wd_n == 10'(WD_MAX)) begin
                    state_n = ERR;
                    err_n   = 1'b1;
                end else if (state == WAIT) begin
                    // mpq_busy is still stale on the first WAIT cycle.
                    if (!fresh && !mpq_busy) begin
                        ack_n   = NREQ'(1) << owner;
                        state_n = IDLE;
                    end
                end else if (!acked) begin
                    if (mpq_done) begin
                        ack_n   = NREQ'(1) << owner;
                        acked_n = 1'b1;
                    end
                end else if (!mpq_busy) begin
                    state_n = IDLE;
                end
            end
            default: state_n = state;
        endcase
    end
endmodule

// File: tb/tb_mpq_cmd_arbiter.sv
// tb_mpq_cmd_arbiter: table, directed and randomized checks of mpq_cmd_arbiter
// against an MPQ stub and a transaction-level reference model.
module tb_mpq_cmd_arbiter;
    logic        clk = 1'b0, rst = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] req_cmd = '0;
    logic [31:0] req_index = '0, req_value = '0;
    logic [3:0]  gnt, ack;
    logic        mpq_cmd_valid, wd_err;
    logic        mpq_busy = 1'b0, mpq_done = 1'b0;
    logic [2:0]  mpq_cmd;
    logic [7:0]  mpq_index, mpq_value;
    logic [28:0] outs;
    int n_cmp = 0, n_fail = 0, cyc = 0, gnt_cnt = 0, ack_cnt = 0, vcnt = 0;

    int s_ph = 0, s_cnt = 0, s_lat = 0;
    bit s_stuck = 1'b0, rnd = 1'b0;
    logic [2:0] s_cmd = '0;

    bit mdl_on = 1'b0, m_out = 1'b0, m_acked = 1'b0;
    int m_own = 0, m_last = 3, m_age = 0;
    logic [2:0]  m_cmd = '0;
    logic [7:0]  m_idx = '0, m_val = '0;
    logic [3:0]  p_req = '0, p_ack = '0;
    logic [11:0] p_cmd = '0;
    logic [31:0] p_idx = '0, p_val = '0;
    logic        p_busy = 1'b0, p_done = 1'b0;

    typedef struct {
        int         r;
        logic [2:0] cmd;
        logic [7:0] idx;
        logic [7:0] val;
        int         lat;
        logic [3:0] egnt;
        int         gap;
    } vec_t;
    vec_t tv[6];

    mpq_cmd_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_index(req_index),
        .req_value(req_value), .gnt(gnt), .ack(ack), .mpq_cmd_valid(mpq_cmd_valid),
        .mpq_cmd(mpq_cmd), .mpq_index(mpq_index), .mpq_value(mpq_value),
        .mpq_busy(mpq_busy), .mpq_done(mpq_done), .wd_err(wd_err)
    );

    assign outs = {gnt, ack, mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value, wd_err};
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat();
        return rnd ? int'($urandom_range(0, 6)) : s_lat;
    endfunction

    task automatic put(input int r, input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
        req_cmd[3*r +: 3]   = c;
        req_index[8*r +: 8] = i;
        req_value[8*r +: 8] = v;
    endtask

    // One clock: sample at negedge, run the reference model, then advance the MPQ stub.
    task automatic step();
        logic [3:0] e_gnt, e_ack, elig;
        bit was_out;
        int w;
        p_req  = req;
        p_cmd  = req_cmd;
        p_idx  = req_index;
        p_val  = req_value;
        p_busy = mpq_busy;
        p_done = mpq_done;
        @(negedge clk);
        cyc++;
        if (|gnt) gnt_cnt++;
        if (|ack) ack_cnt++;
        if (mpq_cmd_valid) vcnt++;
        if (mdl_on) begin
            was_out = m_out;
            e_ack = '0;
            e_gnt = '0;
            if (m_out) begin
                if (m_cmd < 3'd4) begin
                    if (m_age >= 2 && !p_busy) begin
                        e_ack = 4'b1 << m_own;
                        m_out = 1'b0;
                    end
                end else if (!m_acked) begin
                    if (m_age >= 1 && p_done) begin
                        e_ack   = 4'b1 << m_own;
                        m_acked = 1'b1;
                    end
                end else if (!p_busy) begin
                    m_out = 1'b0;
                end
                m_age++;
            end
            elig = p_req & ~p_ack;
            if (!was_out && !p_busy && elig != 4'b0) begin
                w = -1;
                for (int k = 1; k <= 4; k++)
                    if (w < 0 && elig[(m_last + k) % 4]) w = (m_last + k) % 4;
                e_gnt   = 4'b1 << w;
                m_own   = w;
                m_last  = w;
                m_cmd   = p_cmd[3*w +: 3];
                m_idx   = p_idx[8*w +: 8];
                m_val   = p_val[8*w +: 8];
                m_out   = 1'b1;
                m_acked = 1'b0;
                m_age   = 0;
            end
            chk("rand_gnt_ack_valid_err", 32'({gnt, ack, mpq_cmd_valid, wd_err}),
                32'({e_gnt, e_ack, |e_gnt, 1'b0}));
            if (e_gnt != 4'b0)
                chk("rand_operands", 32'({mpq_cmd, mpq_index, mpq_value}), 32'({m_cmd, m_idx, m_val}));
            p_ack = e_ack;
        end
        mpq_done = 1'b0;
        if (mpq_cmd_valid) begin
            s_ph     = 1;
            s_cmd    = mpq_cmd;
            s_cnt    = lat();
            mpq_busy = 1'b1;
        end else if (s_ph == 1 && !s_stuck) begin
            if (s_cnt != 0) s_cnt--;
            else if (s_cmd < 3'd4) begin
                s_ph     = 0;
                mpq_busy = 1'b0;
            end else begin
                s_ph     = 2;
                s_cnt    = lat();
                mpq_done = 1'b1;
            end
        end else if (s_ph == 2) begin
            if (s_cnt != 0) s_cnt--;
            else begin
                s_ph     = 0;
                mpq_busy = 1'b0;
            end
        end
    endtask

    task automatic wait_for(input int which, input int lim, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            step();
            ok = (which == 0) ? |gnt : (which == 1) ? |ack : wd_err;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no event within %0d cycles, expected one", nm, lim);
        end
    endtask

    task automatic do_rst();
        s_ph     = 0;
        mpq_busy = 1'b0;
        mpq_done = 1'b0;
        req      = '0;
        rst      = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        int g, c0, c1;
        logic [19:0] ord;
        tv[0] = '{0, 3'd0, 8'h00, 8'h00, 0, 4'b0001, 3};
        tv[1] = '{2, 3'd3, 8'h00, 8'h05, 1, 4'b0100, 3};
        tv[2] = '{1, 3'd4, 8'h12, 8'h34, 3, 4'b0010, 5};
        tv[3] = '{3, 3'd2, 8'hFF, 8'hA5, 5, 4'b1000, 7};
        tv[4] = '{3, 3'd7, 8'h80, 8'h7F, 0, 4'b1000, 2};
        tv[5] = '{1, 3'd1, 8'h55, 8'hAA, 2, 4'b0010, 4};

        #3 rst = 1'b1;
        #1 chk("reset_outputs", 32'(outs), 32'h0);
        do_rst();

        // Busy MPQ after reset holds off the grant.
        mpq_busy = 1'b1;
        put(0, 3'd0, 8'h11, 8'h22);
        req = 4'b0001;
        c0  = gnt_cnt;
        repeat (6) step();
        chk("busy_blocks_gnt", gnt_cnt - c0, 0);
        c1       = vcnt;
        mpq_busy = 1'b0;
        wait_for(0, 10, "busy_gnt_timeout");
        chk("busy_gnt", 32'(gnt), 32'h1);
        wait_for(1, 20, "busy_ack_timeout");
        chk("busy_ack", 32'(ack), 32'h1);
        chk("busy_single_valid", vcnt - c1, 1);
        req = '0;

        for (int i = 0; i < 6; i++) begin
            s_lat = tv[i].lat;
            put(tv[i].r, tv[i].cmd, tv[i].idx, tv[i].val);
            req = 4'b1 << tv[i].r;
            wait_for(0, 40, "tbl_gnt_timeout");
            g = cyc;
            chk("tbl_gnt", 32'(gnt), 32'(tv[i].egnt));
            chk("tbl_issue", 32'({mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value}),
                32'({1'b1, tv[i].cmd, tv[i].idx, tv[i].val}));
            wait_for(1, 40, "tbl_ack_timeout");
            chk("tbl_ack", 32'(ack), 32'(tv[i].egnt));
            chk("tbl_gap", cyc - g, tv[i].gap);
            chk("tbl_hold", 32'({mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value}),
                32'({1'b0, tv[i].cmd, tv[i].idx, tv[i].val}));
            req = '0;
        end

        // All four requesting: rotation starts at requester 0.
        do_rst();
        s_lat = 1;
        for (int r = 0; r < 4; r++) put(r, 3'd1, 8'(r), 8'(r + 1));
        req = 4'hF;
        ord = '0;
        for (int k = 0; k < 5; k++) begin
            wait_for(0, 20, "rr_gnt_timeout");
            ord = {ord[15:0], gnt};
            c0  = gnt_cnt;
            wait_for(1, 20, "rr_ack_timeout");
            chk("rr_no_gnt_before_ack", gnt_cnt - c0, 0);
            chk("rr_ack_owner", 32'(ack), 32'(ord[3:0]));
        end
        chk("rr_order", 32'(ord), 32'h12481);
        req = '0;

        // Stuck MPQ trips the watchdog.
        do_rst();
        s_stuck = 1'b1;
        put(2, 3'd2, 8'h33, 8'h44);
        req = 4'b0100;
        wait_for(0, 10, "wd_gnt_timeout");
        g  = cyc;
        c0 = gnt_cnt;
        c1 = ack_cnt;
        wait_for(2, 1100, "wd_timeout");
        chk("wd_latency", cyc - g, 1024);
        s_stuck  = 1'b0;
        s_ph     = 0;
        mpq_busy = 1'b0;
        repeat (8) step();
        chk("wd_no_ack", ack_cnt - c1, 0);
        chk("err_no_gnt", gnt_cnt - c0, 0);
        chk("wd_sticky", 32'(wd_err), 32'h1);
        do_rst();
        chk("wd_cleared", 32'(wd_err), 32'h0);

        // Reset in the middle of a command.
        s_lat = 20;
        put(1, 3'd1, 8'h66, 8'h77);
        req = 4'b0010;
        wait_for(0, 10, "mid_gnt_timeout");
        repeat (2) step();
        c1 = ack_cnt;
        #2 rst = 1'b1;
        #1 chk("async_rst_outputs", 32'(outs), 32'h0);
        s_ph     = 0;
        mpq_busy = 1'b0;
        put(0, 3'd2, 8'h01, 8'h02);
        put(3, 3'd2, 8'h03, 8'h04);
        req = 4'b1011;
        step();
        rst = 1'b0;
        wait_for(0, 10, "post_rst_gnt_timeout");
        chk("post_rst_first_gnt", 32'(gnt), 32'h1);
        chk("post_rst_no_ack", ack_cnt - c1, 0);
        req = '0;

        // Random traffic against the reference model.
        do_rst();
        rnd    = 1'b1;
        m_out  = 1'b0;
        m_last = 3;
        p_ack  = '0;
        mdl_on = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            step();
            for (int r = 0; r < 4; r++) begin
                if (ack[r]) req[r] = 1'b0;
                else if (gnt[r] && $urandom_range(0, 3) == 0) req[r] = 1'b0;
                else if (!req[r] && $urandom_range(0, 2) == 0) begin
                    put(r, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                    req[r] = 1'b1;
                end
            end
        end
        mdl_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
